// File: rtl/axi_addr_xbar.sv
// AXI address-channel crossbar: round-robin arbitration of NUM_M masters onto NUM_S decoded slaves plus a default slave.
// Optional macro AXI_XBAR_BACKTOBACK_EN re-arbitrates on the handshake cycle, giving one address per cycle.
module axi_addr_xbar #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [NUM_S*ADDR_BITS-1:0] S_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_BITS-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  localparam int IDS_BITS = ID_BITS + 4,
  localparam int MW       = $clog2(NUM_M)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_M*ID_BITS-1:0]      ID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]    ADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]     LEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0]    SIZE_M,
  input  logic [NUM_M*2-1:0]            BURST_M,
  input  logic [NUM_M-1:0]              VALID_M,
  output logic [NUM_M-1:0]              READY_M,
  output logic [NUM_S*IDS_BITS-1:0]     ID_S,
  output logic [NUM_S*ADDR_BITS-1:0]    ADDR_S,
  output logic [NUM_S*LEN_BITS-1:0]     LEN_S,
  output logic [NUM_S*SIZE_BITS-1:0]    SIZE_S,
  output logic [NUM_S*2-1:0]            BURST_S,
  output logic [NUM_S-1:0]              VALID_S,
  input  logic [NUM_S-1:0]              READY_S,
  output logic                          DEF_VALID,
  output logic [IDS_BITS-1:0]           DEF_ID,
  input  logic                          DEF_READY,
  output logic [MW-1:0]                 grant_idx,
  output logic                          busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MW-1:0]          r_rr_ptr;
  logic [MW-1:0]          r_grant_idx;
  logic [ID_BITS-1:0]     r_id;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [LEN_BITS-1:0]    r_len;
  logic [SIZE_BITS-1:0]   r_size;
  logic [1:0]             r_burst;
  logic [NUM_S-1:0]       r_sel;
  logic                   r_def;

  logic                   w_req_any;
  logic                   w_found;
  logic [MW-1:0]          w_scan_idx;
  logic [MW-1:0]          w_pick;
  logic [MW-1:0]          w_arb_ptr;
  logic [MW-1:0]          w_rr_next;
  logic                   w_sel_ready;
  logic                   w_hs;
  logic                   w_load;
  logic                   w_rr_upd;
  logic [ADDR_BITS-1:0]   w_pick_addr;
  logic [NUM_S-1:0]       w_pick_dec;
  logic [IDS_BITS-1:0]    w_ids;
  logic [NUM_M-1:0]       w_ready_m;

  // Lowest-index slave whose masked address matches its base; all-zero means decode miss.
  function automatic logic [NUM_S-1:0] f_decode(input logic [ADDR_BITS-1:0] addr);
    logic [NUM_S-1:0] hit;
    logic             found;
    hit   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_S; k++) begin
      if (!found && ((addr & S_MASK[k*ADDR_BITS +: ADDR_BITS]) == S_BASE[k*ADDR_BITS +: ADDR_BITS])) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    return hit;
  endfunction

  assign w_req_any   = |VALID_M;
  assign w_rr_next   = (r_grant_idx == MW'(NUM_M - 1)) ? '0 : r_grant_idx + MW'(1);
  assign w_arb_ptr   = (r_state == GRANT) ? w_rr_next : r_rr_ptr;
  assign w_sel_ready = r_def ? DEF_READY : |(r_sel & READY_S);
  assign w_hs        = (r_state == GRANT) && w_sel_ready;
  assign w_pick_addr = ADDR_M[w_pick*ADDR_BITS +: ADDR_BITS];
  assign w_pick_dec  = f_decode(w_pick_addr);

  // Round-robin scan: first requesting master at or above the pointer, wrapping.
  always_comb begin
    w_pick     = '0;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_scan_idx = MW'((int'(w_arb_ptr) + i) % NUM_M);
      if (!w_found && VALID_M[w_scan_idx]) begin
        w_pick  = w_scan_idx;
        w_found = 1'b1;
      end else begin
        w_pick  = w_pick;
      end
    end
  end

  // Next-state logic: load a request on arbitration, release on handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rr_upd    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_load      = 1'b1;
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_hs) begin
          w_rr_upd = 1'b1;
`ifdef AXI_XBAR_BACKTOBACK_EN
          if (w_req_any) begin
            w_load      = 1'b1;
            w_state_nxt = GRANT;
          end else begin
            w_state_nxt = IDLE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pointer and captured request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_sel       <= '0;
      r_def       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rr_upd) begin
        r_rr_ptr <= w_rr_next;
      end
      if (w_load) begin
        r_grant_idx <= w_pick;
        r_id        <= ID_M[w_pick*ID_BITS +: ID_BITS];
        r_addr      <= w_pick_addr;
        r_len       <= LEN_M[w_pick*LEN_BITS +: LEN_BITS];
        r_size      <= SIZE_M[w_pick*SIZE_BITS +: SIZE_BITS];
        r_burst     <= BURST_M[w_pick*2 +: 2];
        r_sel       <= w_pick_dec;
        r_def       <= ~|w_pick_dec;
      end
    end
  end

  // Only the granted master sees the selected target's ready.
  always_comb begin
    w_ready_m = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if ((r_state == GRANT) && (r_grant_idx == MW'(m))) begin
        w_ready_m[m] = w_sel_ready;
      end else begin
        w_ready_m[m] = 1'b0;
      end
    end
  end

  assign w_ids     = {4'(r_grant_idx), r_id};
  assign ID_S      = {NUM_S{w_ids}};
  assign ADDR_S    = {NUM_S{r_addr}};
  assign LEN_S     = {NUM_S{r_len}};
  assign SIZE_S    = {NUM_S{r_size}};
  assign BURST_S   = {NUM_S{r_burst}};
  assign VALID_S   = (r_state == GRANT) ? r_sel : '0;
  assign DEF_VALID = (r_state == GRANT) && r_def;
  assign DEF_ID    = w_ids;
  assign READY_M   = w_ready_m;
  assign grant_idx = r_grant_idx;
  assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_axi_addr_xbar.sv
// Directed self-checking bench for axi_addr_xbar in its default configuration (2 masters, 2 slaves).
module tb_axi_addr_xbar;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ID_M;
  logic [63:0] ADDR_M;
  logic [7:0]  LEN_M;
  logic [5:0]  SIZE_M;
  logic [3:0]  BURST_M;
  logic [1:0]  VALID_M;
  logic [1:0]  READY_M;
  logic [15:0] ID_S;
  logic [63:0] ADDR_S;
  logic [7:0]  LEN_S;
  logic [5:0]  SIZE_S;
  logic [3:0]  BURST_S;
  logic [1:0]  VALID_S;
  logic [1:0]  READY_S;
  logic        DEF_VALID;
  logic [7:0]  DEF_ID;
  logic        DEF_READY;
  logic [0:0]  grant_idx;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  axi_addr_xbar dut (
    .clk(clk), .rst(rst),
    .ID_M(ID_M), .ADDR_M(ADDR_M), .LEN_M(LEN_M), .SIZE_M(SIZE_M), .BURST_M(BURST_M),
    .VALID_M(VALID_M), .READY_M(READY_M),
    .ID_S(ID_S), .ADDR_S(ADDR_S), .LEN_S(LEN_S), .SIZE_S(SIZE_S), .BURST_S(BURST_S),
    .VALID_S(VALID_S), .READY_S(READY_S),
    .DEF_VALID(DEF_VALID), .DEF_ID(DEF_ID), .DEF_READY(DEF_READY),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; VALID_M = 2'b11; READY_S = 2'b11; DEF_READY = 1'b1;
    ID_M = 8'h00; ADDR_M = 64'h0; LEN_M = 8'h00; SIZE_M = 6'h00; BURST_M = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL reset_valid_s: got %b expected 00", VALID_S); end
    n_cmp++; if (DEF_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_def_valid: got %b expected 0", DEF_VALID); end
    n_cmp++; if (READY_M !== 2'b00) begin n_fail++; $display("FAIL reset_ready_m: got %b expected 00", READY_M); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    n_cmp++; if (ADDR_S !== 64'h0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", ADDR_S); end
    @(posedge clk); #1;
    rst = 1'b0; VALID_M = 2'b00; READY_S = 2'b00; DEF_READY = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    ID_M[3:0] = 4'd3; ADDR_M[31:0] = 32'h0001_0004; VALID_M = 2'b01; READY_S = 2'b10;
    @(negedge clk);
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL single_idle_valid_s: got %b expected 00", VALID_S); end
    n_cmp++; if (READY_M !== 2'b00) begin n_fail++; $display("FAIL single_idle_ready_m: got %b expected 00", READY_M); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (VALID_S !== 2'b10) begin n_fail++; $display("FAIL single_valid_s: got %b expected 10", VALID_S); end
    n_cmp++; if (ID_S[15:8] !== 8'h03) begin n_fail++; $display("FAIL single_id_s1: got %h expected 03", ID_S[15:8]); end
    n_cmp++; if (ADDR_S[63:32] !== 32'h0001_0004) begin n_fail++; $display("FAIL single_addr_s1: got %h expected 00010004", ADDR_S[63:32]); end
    n_cmp++; if (READY_M !== 2'b01) begin n_fail++; $display("FAIL single_ready_m: got %b expected 01", READY_M); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    VALID_M = 2'b00; READY_S = 2'b00;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL single_done_valid_s: got %b expected 00", VALID_S); end
  endtask

  task automatic test_decode_miss();
    @(posedge clk); #1;
    ID_M[7:4] = 4'd2; ADDR_M[63:32] = 32'h0005_0000; VALID_M = 2'b10; READY_S = 2'b11; DEF_READY = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (DEF_VALID !== 1'b1) begin n_fail++; $display("FAIL miss_def_valid: got %b expected 1", DEF_VALID); end
    n_cmp++; if (DEF_ID !== 8'h12) begin n_fail++; $display("FAIL miss_def_id: got %h expected 12", DEF_ID); end
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL miss_valid_s: got %b expected 00", VALID_S); end
    n_cmp++; if (READY_M !== 2'b00) begin n_fail++; $display("FAIL miss_ready_wait: got %b expected 00", READY_M); end
    n_cmp++; if (grant_idx !== 1'b1) begin n_fail++; $display("FAIL miss_grant_idx: got %0d expected 1", grant_idx); end
    @(posedge clk); #1;
    DEF_READY = 1'b1;
    @(negedge clk);
    n_cmp++; if (READY_M !== 2'b10) begin n_fail++; $display("FAIL miss_ready_m: got %b expected 10", READY_M); end
    @(posedge clk); #1;
    VALID_M = 2'b00; DEF_READY = 1'b0; READY_S = 2'b00;
    @(negedge clk);
    n_cmp++; if (DEF_VALID !== 1'b0) begin n_fail++; $display("FAIL miss_done_def_valid: got %b expected 0", DEF_VALID); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL miss_done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    logic       exp_m;
    logic [1:0] exp_vs;
    logic [7:0] exp_id;
    @(posedge clk); #1;
    ID_M = 8'h51; ADDR_M = {32'h0001_0020, 32'h0000_0010}; VALID_M = 2'b11; READY_S = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_m  = (i % 2 == 1);
      exp_vs = exp_m ? 2'b10 : 2'b01;
      exp_id = exp_m ? 8'h15 : 8'h01;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (grant_idx !== exp_m) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, grant_idx, exp_m); end
      n_cmp++; if (VALID_S !== exp_vs) begin n_fail++; $display("FAIL rr_valid_s_%0d: got %b expected %b", i, VALID_S, exp_vs); end
      n_cmp++; if (ID_S[15:8] !== exp_id) begin n_fail++; $display("FAIL rr_id_s_%0d: got %h expected %h", i, ID_S[15:8], exp_id); end
      n_cmp++; if (READY_M !== (exp_m ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ready_m_%0d: got %b", i, READY_M); end
      @(posedge clk); #1;
      if (i == 3) VALID_M = 2'b00;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_release_%0d: got busy %b expected 0", i, busy); end
    end
    READY_S = 2'b00;
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    ID_M[3:0] = 4'd7; ADDR_M[31:0] = 32'h0000_0100; LEN_M[3:0] = 4'hF; SIZE_M[2:0] = 3'd2; BURST_M[1:0] = 2'b01;
    VALID_M = 2'b01; READY_S = 2'b00;
    @(posedge clk); #1;
    VALID_M = 2'b00; ADDR_M[31:0] = 32'hDEAD_0000; LEN_M[3:0] = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (VALID_S !== 2'b01) begin n_fail++; $display("FAIL bp_valid_s_%0d: got %b expected 01", c, VALID_S); end
      n_cmp++; if (ADDR_S[31:0] !== 32'h0000_0100) begin n_fail++; $display("FAIL bp_addr_%0d: got %h expected 00000100", c, ADDR_S[31:0]); end
      n_cmp++; if (READY_M !== 2'b00) begin n_fail++; $display("FAIL bp_ready_m_%0d: got %b expected 00", c, READY_M); end
      @(posedge clk); #1;
    end
    READY_S = 2'b01;
    @(negedge clk);
    n_cmp++; if (READY_M !== 2'b01) begin n_fail++; $display("FAIL bp_ready_m: got %b expected 01", READY_M); end
    n_cmp++; if ({LEN_S[3:0], SIZE_S[2:0], BURST_S[1:0]} !== {4'hF, 3'd2, 2'b01}) begin n_fail++; $display("FAIL bp_payload: got %h/%h/%h expected f/2/1", LEN_S[3:0], SIZE_S[2:0], BURST_S[1:0]); end
    @(posedge clk); #1;
    READY_S = 2'b00;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_done_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    READY_S = 2'b01;
    @(negedge clk);
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL bp_single_hs: got %b expected 00", VALID_S); end
    READY_S = 2'b00;
  endtask

  task automatic test_reset_in_grant();
    @(posedge clk); #1;
    ADDR_M = 64'h0; ID_M = 8'h9A; VALID_M = 2'b11; READY_S = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (grant_idx !== 1'b1) begin n_fail++; $display("FAIL rig_rr_grant: got %0d expected 1", grant_idx); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rig_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1; VALID_M = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rig_busy_after: got %b expected 0", busy); end
    n_cmp++; if (VALID_S !== 2'b00) begin n_fail++; $display("FAIL rig_valid_s: got %b expected 00", VALID_S); end
    n_cmp++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL rig_grant_idx: got %0d expected 0", grant_idx); end
    @(posedge clk); #1;
    VALID_M = 2'b11; READY_S = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL rig_rr_reset: got %0d expected 0", grant_idx); end
    n_cmp++; if (ID_S[7:0] !== 8'h0A) begin n_fail++; $display("FAIL rig_id_s0: got %h expected 0a", ID_S[7:0]); end
    @(posedge clk); #1;
    VALID_M = 2'b00; READY_S = 2'b00;
    @(negedge clk);
  endtask

`ifdef AXI_XBAR_BACKTOBACK_EN
  task automatic test_back_to_back();
    @(posedge clk); #1;
    ADDR_M = 64'h0; VALID_M = 2'b01; READY_S = 2'b11;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (READY_M !== 2'b01) begin n_fail++; $display("FAIL b2b_hs_%0d: got %b expected 01", c, READY_M); end
      @(posedge clk); #1;
      if (c == 1) VALID_M = 2'b00;
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy: got %b expected 0", busy); end
    READY_S = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_decode_miss();
    test_contention();
    test_backpressure();
    test_reset_in_grant();
`ifdef AXI_XBAR_BACKTOBACK_EN
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_addr_xbar.md
AXI_ADDR_XBAR -- requirements
Module: axi_addr_xbar

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameter NUM_M, default 2, SHALL set the number of master ports (2..8).
REQ-003 Parameter NUM_S, default 2, SHALL set the number of decoded slave ports (1..8), excluding the default slave.
REQ-004 Parameters ID_BITS=4, ADDR_BITS=32, LEN_BITS=4 and SIZE_BITS=3 SHALL set the field widths; IDS_BITS SHALL be fixed at ID_BITS+4.
REQ-005 Parameters S_BASE and S_MASK, each NUM_S*ADDR_BITS wide, SHALL give the per-slave base and mask; defaults are slave0 0x0000_0000/0xFFFF_0000 and slave1 0x0001_0000/0xFFFF_0000.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ID_M  in  NUM_M*ID_BITS  master IDs
- ADDR_M  in  NUM_M*ADDR_BITS  master addresses
- LEN_M  in  NUM_M*LEN_BITS  master burst lengths
- SIZE_M  in  NUM_M*SIZE_BITS  master beat sizes
- BURST_M  in  NUM_M*2  master burst types
- VALID_M  in  NUM_M  master address valid
- READY_M  out  NUM_M  master address ready
- ID_S  out  NUM_S*IDS_BITS  slave IDs, {4'(master index), ID}
- ADDR_S, LEN_S, SIZE_S, BURST_S  out  NUM_S*field  slave payload
- VALID_S  out  NUM_S  slave address valid
- READY_S  in  NUM_S  slave address ready
- DEF_VALID  out  1  valid to the default (decode-error) slave
- DEF_ID  out  IDS_BITS  ID to the default slave
- DEF_READY  in  1  ready from the default slave
- grant_idx  out  $clog2(NUM_M)  current or last granted master
- busy  out  1  high while state is GRANT

Function
REQ-007 The FSM SHALL have two states: IDLE and GRANT.
REQ-008 In IDLE, when any VALID_M bit is high, the block SHALL pick one master round-robin, starting from rr_ptr and searching upward with wrap-around.
REQ-009 On the edge that leaves IDLE, the block SHALL register grant_idx, the payload, and a one-hot decode result, then enter GRANT.
REQ-010 Decode SHALL match slave k when (ADDR & S_MASK[k]) == S_BASE[k]; the lowest matching k wins; no match selects the default slave.
REQ-011 In GRANT, exactly one of VALID_S[k] and DEF_VALID SHALL be high, driven from the registered decode, and the payload outputs SHALL carry the registered values.
REQ-012 Non-selected VALID_S bits SHALL be 0; payload outputs SHALL be broadcast to all slaves.
REQ-013 READY_M[grant_idx] SHALL equal the selected target's READY while in GRANT; every other READY_M bit SHALL be 0, and all READY_M bits SHALL be 0 in IDLE.
REQ-014 A handshake SHALL occur when the selected VALID and READY are both high; on that edge rr_ptr SHALL become (grant_idx+1) mod NUM_M and the state SHALL become IDLE.
REQ-015 Latency SHALL be one cycle from VALID_M to VALID_S; throughput SHALL be one address per two cycles.
REQ-016 A master dropping VALID_M while granted SHALL NOT abort the grant; VALID_S SHALL stay high until the handshake.
REQ-017 Requests arriving while in GRANT SHALL wait; the arbiter SHALL NOT re-evaluate until IDLE.
REQ-018 DEF_ID SHALL carry the same {master index, ID} formatting as ID_S.

Reset
REQ-019 While rst is high at a clk edge: state SHALL be IDLE, rr_ptr 0, grant_idx 0, busy 0, and all VALID_S, DEF_VALID and READY_M bits 0.
REQ-020 While rst is high, payload registers SHALL be 0.
REQ-021 A reset asserted in GRANT SHALL discard the pending request without a handshake.

Configuration
REQ-022 When AXI_XBAR_BACKTOBACK_EN is defined, on a handshake with another VALID_M pending, the block SHALL re-arbitrate in the same cycle using the updated rr_ptr, stay in GRANT, and load the new request, giving one address per cycle.
REQ-023 When AXI_XBAR_BACKTOBACK_EN is undefined, the block SHALL behave per REQ-014.

Verification
REQ-024 Reset test: rst=1 for 2 cycles with all VALID_M=1 -> all VALID_S, DEF_VALID and READY_M are 0 and busy=0.
REQ-025 Single master: M0 sends ADDR 0x0001_0004 with ID 3, READY_S1=1 -> VALID_S[1]=1 one cycle later, ID_S1=0x03, READY_M[0]=1 for one cycle, then IDLE.
REQ-026 Contention: M0 and M1 hold VALID for 4 requests, all slaves ready -> grants alternate M0, M1, M0, M1.
REQ-027 Decode miss: M1 sends ADDR 0x0005_0000 with ID 2 -> DEF_VALID=1, DEF_ID=0x12, no VALID_S bit set; DEF_READY=1 completes the handshake.
REQ-028 Backpressure: READY_S0=0 for 5 cycles and M0 drops VALID after 1 cycle -> VALID_S[0] held with a stable payload until READY_S0=1, then one handshake.
REQ-029 With AXI_XBAR_BACKTOBACK_EN defined: 3 back-to-back requests from M0 with slaves ready -> handshakes on 3 consecutive cycles.
